// File: rtl/uart_tx_frame_serializer_pkg.sv
// Shared types and helpers for the UART TX frame serializer.
//   rd_state_t : read-side FSM states (S_CSUM only used with
//                UART_TX_FRAME_SERIALIZER_CHECKSUM_EN defined)
//   len_w()    : width of a frame-length field for a given depth
//   idx_w()    : width of a word index for a given depth
//   clamp_len(): maps a length of 0 or above depth onto depth
package uart_tx_frame_serializer_pkg;

  typedef enum logic {
    S_DATA = 1'b0,
    S_CSUM = 1'b1
  } rd_state_t;

  function automatic int unsigned len_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned idx_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned depth);
    return ((len == 0) || (len > depth)) ? depth : len;
  endfunction

endpackage

// File: rtl/uart_tx_frame_bank.sv
// One storage bank of the frame serializer: holds a frame of DEPTH words,
// its stored length and a full flag.
//   clk, arstn : clock, asynchronous active-low reset (full flag only)
//   set_i      : capture data_i/len_i and mark the bank full
//   clr_i      : release the bank (mark empty)
//   data_i     : frame words to capture
//   len_i      : clamped frame length to capture
//   full_o     : bank holds an unsent frame
//   data_o     : stored frame words
//   len_o      : stored frame length
module uart_tx_frame_bank #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LEN_W = 3
) (
  input  logic                         clk,
  input  logic                         arstn,
  input  logic                         set_i,
  input  logic                         clr_i,
  input  logic [DEPTH-1:0][WIDTH-1:0]  data_i,
  input  logic [LEN_W-1:0]             len_i,
  output logic                         full_o,
  output logic [DEPTH-1:0][WIDTH-1:0]  data_o,
  output logic [LEN_W-1:0]             len_o
);

  logic                        full_q, full_d;
  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [LEN_W-1:0]            len_q, len_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    len_d  = len_q;
    if (set_i) begin
      full_d = 1'b1;
      data_d = data_i;
      len_d  = len_i;
    end else if (clr_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      full_q <= 1'b0;
    end else begin
      full_q <= full_d;
    end
  end

  // Contents are only meaningful while full, so they carry no reset.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    len_q  <= len_d;
  end

  assign full_o = full_q;
  assign data_o = data_q;
  assign len_o  = len_q;

endmodule

// File: rtl/uart_tx_frame_serializer.sv
// Ping-pong frame buffer: accepts a whole frame of up to DEPTH words in one
// beat and streams it out word by word towards a UART transmitter.
//   clk, arstn         : clock, asynchronous active-low reset
//   up_valid/up_ready  : frame handshake (up_ready from registered state)
//   up_data, up_len    : frame words and length (0 or >DEPTH means DEPTH)
//   down_valid/ready   : serial word handshake
//   down_data          : current word
//   down_last          : current word ends the frame
//   frame_done         : one-cycle pulse after the final word is accepted
//   frames_pending     : number of full banks (0..2)
// Optional: define UART_TX_FRAME_SERIALIZER_CHECKSUM_EN to append one XOR
// checksum word after the data words of every frame.
module uart_tx_frame_serializer
  import uart_tx_frame_serializer_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned LSB_WORD_FIRST = 1,
  localparam int unsigned LEN_W         = len_w(DEPTH),
  localparam int unsigned IDX_W         = idx_w(DEPTH)
) (
  input  logic                         clk,
  input  logic                         arstn,
  input  logic                         up_valid,
  output logic                         up_ready,
  input  logic [DEPTH-1:0][WIDTH-1:0]  up_data,
  input  logic [LEN_W-1:0]             up_len,
  output logic                         down_valid,
  input  logic                         down_ready,
  output logic [WIDTH-1:0]             down_data,
  output logic                         down_last,
  output logic                         frame_done,
  output logic [1:0]                   frames_pending
);

  logic [1:0]                  bank_set;
  logic [1:0]                  bank_clr;
  logic [1:0]                  bank_full;
  logic [DEPTH-1:0][WIDTH-1:0] bank_data [2];
  logic [LEN_W-1:0]            bank_len  [2];

  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic             frame_done_q, frame_done_d;

  logic [LEN_W-1:0] up_len_clamped;
  logic [LEN_W-1:0] cur_len;
  logic [LEN_W-1:0] rd_pos;
  logic [LEN_W-1:0] word_sel;
  logic [WIDTH-1:0] cur_word;
  logic             accept;
  logic             pop;
  logic             data_last;
  logic             release_bank;

`ifdef UART_TX_FRAME_SERIALIZER_CHECKSUM_EN
  rd_state_t        state_q, state_d;
  logic [WIDTH-1:0] csum_q, csum_d;
`endif

  assign up_len_clamped = LEN_W'(clamp_len(32'(up_len), DEPTH));

  for (genvar g = 0; g < 2; g++) begin : g_bank
    uart_tx_frame_bank #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .LEN_W (LEN_W)
    ) u_bank (
      .clk    (clk),
      .arstn  (arstn),
      .set_i  (bank_set[g]),
      .clr_i  (bank_clr[g]),
      .data_i (up_data),
      .len_i  (up_len_clamped),
      .full_o (bank_full[g]),
      .data_o (bank_data[g]),
      .len_o  (bank_len[g])
    );
  end

  always_comb begin
    up_ready   = ~bank_full[wr_bank_q];
    accept     = up_valid & up_ready;
    down_valid = bank_full[rd_bank_q];
    pop        = down_valid & down_ready;

    cur_len   = bank_len[rd_bank_q];
    rd_pos    = LEN_W'(rd_idx_q);
    data_last = (rd_pos == cur_len - LEN_W'(1));
    word_sel  = (LSB_WORD_FIRST != 0) ? rd_pos
                                      : cur_len - LEN_W'(1) - rd_pos;
    cur_word  = bank_data[rd_bank_q][IDX_W'(word_sel)];

    rd_idx_d     = rd_idx_q;
    release_bank = 1'b0;
    down_data    = cur_word;
    down_last    = 1'b0;

`ifdef UART_TX_FRAME_SERIALIZER_CHECKSUM_EN
    state_d = state_q;
    csum_d  = csum_q;
    case (state_q)
      S_DATA: begin
        if (pop) begin
          csum_d = csum_q ^ cur_word;
          // Index stays parked on the last word; it is cleared on release.
          if (data_last) begin
            state_d = S_CSUM;
          end else begin
            rd_idx_d = rd_idx_q + IDX_W'(1);
          end
        end
      end
      S_CSUM: begin
        down_data = csum_q;
        down_last = down_valid;
        if (pop) begin
          release_bank = 1'b1;
          state_d      = S_DATA;
          csum_d       = '0;
          rd_idx_d     = '0;
        end
      end
      default: state_d = S_DATA;
    endcase
`else
    down_last = down_valid & data_last;
    if (pop) begin
      if (data_last) begin
        release_bank = 1'b1;
        rd_idx_d     = '0;
      end else begin
        rd_idx_d = rd_idx_q + IDX_W'(1);
      end
    end
`endif

    wr_bank_d    = accept ? ~wr_bank_q : wr_bank_q;
    rd_bank_d    = release_bank ? ~rd_bank_q : rd_bank_q;
    frame_done_d = release_bank;

    // Set and clear never hit the same bank: set needs it empty, clear full.
    bank_set = {accept & wr_bank_q, accept & ~wr_bank_q};
    bank_clr = {release_bank & rd_bank_q, release_bank & ~rd_bank_q};

    frames_pending = {bank_full[0] & bank_full[1], bank_full[0] ^ bank_full[1]};
    frame_done     = frame_done_q;
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      rd_idx_q     <= '0;
      frame_done_q <= 1'b0;
`ifdef UART_TX_FRAME_SERIALIZER_CHECKSUM_EN
      state_q      <= S_DATA;
      csum_q       <= '0;
`endif
    end else begin
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      rd_idx_q     <= rd_idx_d;
      frame_done_q <= frame_done_d;
`ifdef UART_TX_FRAME_SERIALIZER_CHECKSUM_EN
      state_q      <= state_d;
      csum_q       <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_serializer.sv
module tb_uart_tx_frame_serializer;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int LW = 3;
`ifdef UART_TX_FRAME_SERIALIZER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic                 clk = 1'b0;
  logic                 arstn = 1'b0;
  logic                 up_valid = 1'b0;
  logic                 up_ready;
  logic [D-1:0][W-1:0]  up_data = '0;
  logic [LW-1:0]        up_len = '0;
  logic                 down_valid;
  logic                 down_ready = 1'b0;
  logic [W-1:0]         down_data;
  logic                 down_last;
  logic                 frame_done;
  logic [1:0]           frames_pending;

  int checks = 0;
  int failures = 0;

  logic [8:0] q[$];

  uart_tx_frame_serializer #(
    .WIDTH          (W),
    .DEPTH          (D),
    .LSB_WORD_FIRST (1)
  ) dut (
    .clk            (clk),
    .arstn          (arstn),
    .up_valid       (up_valid),
    .up_ready       (up_ready),
    .up_data        (up_data),
    .up_len         (up_len),
    .down_valid     (down_valid),
    .down_ready     (down_ready),
    .down_data      (down_data),
    .down_last      (down_last),
    .frame_done     (frame_done),
    .frames_pending (frames_pending)
  );

  always #5 clk = ~clk;

  function automatic int eff_len(input int l);
    return ((l == 0) || (l > D)) ? D : l;
  endfunction

  // i < length: data word i; i == length: XOR checksum of the frame
  function automatic logic [W-1:0] exp_word(input logic [D-1:0][W-1:0] d,
                                            input int l, input int i);
    logic [W-1:0] x;
    int n;
    n = eff_len(l);
    x = '0;
    if (i < n) return d[i];
    for (int j = 0; j < n; j++) x = x ^ d[j];
    return x;
  endfunction

  task automatic test_reset();
    #2;
    checks++;
    if (up_ready !== 1'b1 || down_valid !== 1'b0 || down_last !== 1'b0 ||
        frame_done !== 1'b0 || frames_pending !== 2'd0) begin
      failures++;
      $display("FAIL reset: got rdy=%b vld=%b last=%b done=%b pend=%0d, want 1 0 0 0 0",
               up_ready, down_valid, down_last, frame_done, frames_pending);
    end
    @(negedge clk);
    arstn = 1'b1;
    @(negedge clk);
    checks++;
    if (up_ready !== 1'b1 || down_valid !== 1'b0 || frames_pending !== 2'd0) begin
      failures++;
      $display("FAIL reset_idle: got rdy=%b vld=%b pend=%0d, want 1 0 0",
               up_ready, down_valid, frames_pending);
    end
  endtask

  task automatic test_single_frame();
    logic [D-1:0][W-1:0] f;
    int n;
    f = {8'h44, 8'h33, 8'h22, 8'h11};
    n = 4 + CS;
    up_data = f; up_len = LW'(4); up_valid = 1'b1; down_ready = 1'b1;
    @(negedge clk);
    up_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (down_valid !== 1'b1 || down_data !== exp_word(f, 4, i) ||
          down_last !== (i == n - 1) || frame_done !== 1'b0) begin
        failures++;
        $display("FAIL single_word%0d: got vld=%b data=%h last=%b done=%b, want 1 %h %b 0",
                 i, down_valid, down_data, down_last, frame_done,
                 exp_word(f, 4, i), (i == n - 1));
      end
      @(negedge clk);
    end
    checks++;
    if (frame_done !== 1'b1 || down_valid !== 1'b0 || frames_pending !== 2'd0) begin
      failures++;
      $display("FAIL single_done: got done=%b vld=%b pend=%0d, want 1 0 0",
               frame_done, down_valid, frames_pending);
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0) begin
      failures++;
      $display("FAIL single_done_pulse: got done=%b, want 0", frame_done);
    end
  endtask

  task automatic test_short_and_clamp();
    int lens[3] = '{2, 0, 7};
    logic [D-1:0][W-1:0] f;
    int n;
    f = {8'h44, 8'h33, 8'h22, 8'h11};
    down_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = eff_len(lens[k]) + CS;
      up_data = f; up_len = LW'(lens[k]); up_valid = 1'b1;
      @(negedge clk);
      up_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
        checks++;
        if (down_valid !== 1'b1 || down_data !== exp_word(f, lens[k], i) ||
            down_last !== (i == n - 1)) begin
          failures++;
          $display("FAIL len%0d_word%0d: got vld=%b data=%h last=%b, want 1 %h %b",
                   lens[k], i, down_valid, down_data, down_last,
                   exp_word(f, lens[k], i), (i == n - 1));
        end
        @(negedge clk);
      end
      checks++;
      if (down_valid !== 1'b0 || frame_done !== 1'b1) begin
        failures++;
        $display("FAIL len%0d_end: got vld=%b done=%b, want 0 1",
                 lens[k], down_valid, frame_done);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_ping_pong();
    logic [D-1:0][W-1:0] fr[3];
    int l;
    int fidx;
    int widx;
    fr[0] = {8'h14, 8'h13, 8'h12, 8'h11};
    fr[1] = {8'h24, 8'h23, 8'h22, 8'h21};
    fr[2] = {8'h34, 8'h33, 8'h32, 8'h31};
    l = 4 + CS;
    down_ready = 1'b0;
    up_data = fr[0]; up_len = LW'(4); up_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (up_ready !== 1'b1 || frames_pending !== 2'd1 || down_valid !== 1'b1) begin
      failures++;
      $display("FAIL pp_first: got rdy=%b pend=%0d vld=%b, want 1 1 1",
               up_ready, frames_pending, down_valid);
    end
    up_data = fr[1];
    @(negedge clk);
    checks++;
    if (up_ready !== 1'b0 || frames_pending !== 2'd2) begin
      failures++;
      $display("FAIL pp_full: got rdy=%b pend=%0d, want 0 2", up_ready, frames_pending);
    end
    up_data = fr[2];
    @(negedge clk);
    checks++;
    if (up_ready !== 1'b0 || frames_pending !== 2'd2 || down_data !== 8'h11) begin
      failures++;
      $display("FAIL pp_held: got rdy=%b pend=%0d data=%h, want 0 2 11",
               up_ready, frames_pending, down_data);
    end
    down_ready = 1'b1;
    for (int c = 0; c < 3 * l; c++) begin
      fidx = c / l;
      widx = c % l;
      if (c == l + 1) up_valid = 1'b0;
      checks++;
      if (down_valid !== 1'b1 || down_data !== exp_word(fr[fidx], 4, widx) ||
          down_last !== (widx == l - 1)) begin
        failures++;
        $display("FAIL pp_stream%0d: got vld=%b data=%h last=%b, want 1 %h %b",
                 c, down_valid, down_data, down_last,
                 exp_word(fr[fidx], 4, widx), (widx == l - 1));
      end
      if (c == l - 1) begin
        checks++;
        if (up_ready !== 1'b0) begin
          failures++;
          $display("FAIL pp_no_reuse: got rdy=%b, want 0", up_ready);
        end
      end
      if (c == l) begin
        checks++;
        if (up_ready !== 1'b1 || frames_pending !== 2'd1) begin
          failures++;
          $display("FAIL pp_freed: got rdy=%b pend=%0d, want 1 1", up_ready, frames_pending);
        end
      end
      if (c == l + 1) begin
        checks++;
        if (up_ready !== 1'b0 || frames_pending !== 2'd2) begin
          failures++;
          $display("FAIL pp_third_in: got rdy=%b pend=%0d, want 0 2", up_ready, frames_pending);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (down_valid !== 1'b0 || frame_done !== 1'b1 || frames_pending !== 2'd0) begin
      failures++;
      $display("FAIL pp_end: got vld=%b done=%b pend=%0d, want 0 1 0",
               down_valid, frame_done, frames_pending);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int lens[5] = '{3, 1, 4, 2, 0};
    int fi;
    int n;
    bit pend;
    bit stall;
    logic [W-1:0] pd;
    logic pl;
    logic [8:0] e;
    fi = 0; pend = 0; stall = 0; pd = '0; pl = 1'b0;
    q.delete();
    up_valid = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (stall) begin
        checks++;
        if (down_valid !== 1'b1 || down_data !== pd || down_last !== pl) begin
          failures++;
          $display("FAIL bp_stable cyc%0d: got vld=%b data=%h last=%b, want 1 %h %b",
                   cyc, down_valid, down_data, down_last, pd, pl);
        end
      end
      if (pend) begin
        n = eff_len(int'(up_len)) + CS;
        for (int i = 0; i < n; i++)
          q.push_back({(i == n - 1), exp_word(up_data, int'(up_len), i)});
        fi++;
        up_valid = 1'b0;
      end
      if (!up_valid && fi < 5) begin
        for (int w = 0; w < D; w++) up_data[w] = W'($urandom);
        up_len = LW'(lens[fi]);
        up_valid = 1'b1;
      end
      pend = up_valid && up_ready;
      down_ready = 1'($urandom_range(0, 1));
      if (down_valid && down_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL bp_extra cyc%0d: got data=%h, want no word", cyc, down_data);
        end else begin
          e = q.pop_front();
          if ({down_last, down_data} !== e) begin
            failures++;
            $display("FAIL bp_word cyc%0d: got last=%b data=%h, want %b %h",
                     cyc, down_last, down_data, e[8], e[7:0]);
          end
        end
      end
      stall = down_valid && !down_ready;
      pd = down_data;
      pl = down_last;
      if (fi == 5 && !pend && q.size() == 0 && !down_valid) break;
      @(negedge clk);
    end
    checks++;
    if (fi != 5 || q.size() != 0 || down_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_complete: got frames=%0d left=%0d vld=%b, want 5 0 0",
               fi, q.size(), down_valid);
    end
    down_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    logic [D-1:0][W-1:0] f;
    logic [D-1:0][W-1:0] h;
    int n;
    f = {8'hA4, 8'hA3, 8'hA2, 8'hA1};
    h = {8'h5D, 8'h5C, 8'h5B, 8'h5A};
    n = 4 + CS;
    down_ready = 1'b1;
    up_data = f; up_len = LW'(4); up_valid = 1'b1;
    @(negedge clk);
    up_data = {8'hB4, 8'hB3, 8'hB2, 8'hB1};
    @(negedge clk);
    up_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (down_valid !== 1'b1 || down_data !== 8'hA3 || frames_pending !== 2'd2) begin
      failures++;
      $display("FAIL rst_pre: got vld=%b data=%h pend=%0d, want 1 a3 2",
               down_valid, down_data, frames_pending);
    end
    #2 arstn = 1'b0;
    #1;
    checks++;
    if (down_valid !== 1'b0 || down_last !== 1'b0 || up_ready !== 1'b1 ||
        frames_pending !== 2'd0) begin
      failures++;
      $display("FAIL rst_async: got vld=%b last=%b rdy=%b pend=%0d, want 0 0 1 0",
               down_valid, down_last, up_ready, frames_pending);
    end
    @(negedge clk);
    arstn = 1'b1;
    @(negedge clk);
    checks++;
    if (down_valid !== 1'b0 || frames_pending !== 2'd0) begin
      failures++;
      $display("FAIL rst_discard: got vld=%b pend=%0d, want 0 0", down_valid, frames_pending);
    end
    up_data = h; up_len = LW'(4); up_valid = 1'b1;
    @(negedge clk);
    up_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (down_valid !== 1'b1 || down_data !== exp_word(h, 4, i) ||
          down_last !== (i == n - 1)) begin
        failures++;
        $display("FAIL rst_next_word%0d: got vld=%b data=%h last=%b, want 1 %h %b",
                 i, down_valid, down_data, down_last, exp_word(h, 4, i), (i == n - 1));
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_short_and_clamp();
    test_ping_pong();
    test_backpressure();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
